// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch stage.
package riscv_pkg;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request, one-entry output slot to decode.
// Handshakes: imem request is held (req/addr stable) until imem_gnt; decode takes instr when instr_valid & instr_ready.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned          A_WIDTH  = 32,
  parameter int unsigned          D_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [D_WIDTH-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [D_WIDTH-1:0] instr,
  output logic [A_WIDTH-1:0] instr_pc
);

  fetch_state_t       state_q, state_d;
  logic [A_WIDTH-1:0] pc_q, pc_d;
  // Address of the request being issued / in flight; doubles as the PC of the returned word.
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic               drop_q, drop_d;
  logic               valid_q, valid_d;
  logic [D_WIDTH-1:0] instr_q, instr_d;
  logic [A_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [A_WIDTH-1:0] redirect_tgt;
  logic [1:0]         unused_redirect_lsbs;

  assign redirect_tgt         = {redirect_pc[A_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
          // A pending drop means pc_q already holds a redirect target; keep it.
          if (!drop_q) pc_d = pc_q + A_WIDTH'(PC_STEP);
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!redirect) begin
            instr_d    = imem_rdata;
            instr_pc_d = addr_q;
            valid_d    = 1'b1;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (valid_q && instr_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      pc_d    = redirect_tgt;
      valid_d = 1'b0;
      case (state_q)
        IDLE, HOLD: state_d = REQ;
        REQ:        drop_d  = 1'b1;
        WAIT:       if (!imem_rvalid) drop_d = 1'b1;
        default:    state_d = IDLE;
      endcase
    end

    // Latch the request address only on entry to REQ so it stays stable until grant.
    if ((state_d == REQ) && (state_q != REQ)) addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      drop_q     <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= D_WIDTH'(NOP);
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, program-order scoreboard, directed and random phases.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_accept = 0;
  int          gnt_mode = 1;   // 0 random, 1 always, 2 never
  int          rv_delay = 0;   // <0 random 0..2, else fixed extra cycles
  bit          spurious_en = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] next_pc;

  fetch_unit #(.A_WIDTH(32), .D_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // program-order reference: the sequence of {pc, word} decode must accept
  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    next_pc = pc;
    top_up();
  endtask

  // scoreboard monitor
  initial begin
    logic [63:0] e;
    restart_stream(RST_PC);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        restart_stream(RST_PC);
      end else begin
        if (instr_valid && instr_ready) begin
          e = exp_q.pop_front();
          check("instr_pc", {32'h0, instr_pc}, {32'h0, e[63:32]});
          check("instr", {32'h0, instr}, {32'h0, e[31:0]});
          n_accept++;
          top_up();
        end
        if (redirect) restart_stream({redirect_pc[31:2], 2'b00});
      end
    end
  end

  // instruction memory responder and request-protocol checks
  initial begin
    int          pend;
    int          delay;
    logic [31:0] pend_data;
    logic [31:0] prev_addr;
    bit          prev_wait;
    pend = 0; delay = 0; pend_data = '0; prev_addr = '0; prev_wait = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          check("req_held", {63'h0, imem_req}, 64'h1);
          check("addr_held", {32'h0, imem_addr}, {32'h0, prev_addr});
        end
        if (imem_req) begin
          check("one_outstanding", 64'(pend), 64'h0);
          check("addr_aligned", {62'h0, imem_addr[1:0]}, 64'h0);
        end
        if (imem_req && imem_gnt) begin
          pend      = 1;
          pend_data = mem_word(imem_addr);
          delay     = (rv_delay < 0) ? int'($urandom_range(0, 2)) : rv_delay;
        end
        prev_wait = imem_req && !imem_gnt;
        prev_addr = imem_addr;
      end
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (!rst_n) begin
        pend = 0;
      end else if (pend != 0 && delay == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_data;
        pend        = 0;
      end else if (pend != 0) begin
        delay--;
      end else if (spurious_en && $urandom_range(0, 7) == 0) begin
        imem_rvalid = 1'b1;
      end
      case (gnt_mode)
        0:       imem_gnt = 1'($urandom_range(0, 1));
        1:       imem_gnt = 1'b1;
        default: imem_gnt = 1'b0;
      endcase
    end
  end

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit now);
    bit got;
    got = now && imem_req && imem_gnt;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = imem_req && imem_gnt;
    end
    check("grant_seen", {63'h0, got}, 64'h1);
  endtask

  task automatic wait_grant_addr(input logic [31:0] a);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = imem_req && imem_gnt && (imem_addr == a);
    end
    check("grant_addr_seen", {63'h0, got}, 64'h1);
  endtask

  task automatic wait_req();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = imem_req;
    end
    check("req_seen", {63'h0, got}, 64'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      {63'h0, imem_req},    64'h0);
    check({tag, "_addr"},     {32'h0, imem_addr},   {32'h0, RST_PC});
    check({tag, "_valid"},    {63'h0, instr_valid}, 64'h0);
    check({tag, "_instr"},    {32'h0, instr},       {32'h0, NOP});
    check({tag, "_instr_pc"}, {32'h0, instr_pc},    64'h0);
  endtask

  // main sequence
  initial begin
    logic [31:0] s_instr, s_pc, a_old;
    bit got;
    rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // first fetches with zero-wait memory
    drive_point();
    rst_n = 1'b1;
    @(negedge clk);  // cycle 0
    check("idle_cycle0_req", {63'h0, imem_req}, 64'h0);
    @(negedge clk);  // cycle 1
    check("cycle1_req", {63'h0, imem_req}, 64'h1);
    check("cycle1_addr", {32'h0, imem_addr}, 64'h0);
    @(negedge clk);  // cycle 2
    check("cycle2_valid", {63'h0, instr_valid}, 64'h0);
    @(negedge clk);  // cycle 3
    check("cycle3_valid", {63'h0, instr_valid}, 64'h1);
    @(negedge clk);  // cycle 4
    check("cycle4_addr", {31'h0, imem_req, imem_addr}, {32'h1, 32'h4});
    repeat (3) @(negedge clk);  // cycle 7
    check("cycle7_addr", {31'h0, imem_req, imem_addr}, {32'h1, 32'h8});

    // back-pressure in HOLD
    drive_point();
    instr_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = instr_valid;
    end
    check("hold_valid_seen", {63'h0, got}, 64'h1);
    s_instr = instr;
    s_pc    = instr_pc;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_instr", {32'h0, instr}, {32'h0, s_instr});
      check("hold_pc", {32'h0, instr_pc}, {32'h0, s_pc});
      check("hold_no_req", {62'h0, imem_req, instr_valid}, 64'h1);
    end
    drive_point();
    instr_ready = 1'b1;
    rv_delay    = 2;
    @(negedge clk);
    check("hold_release_no_req", {63'h0, imem_req}, 64'h0);
    @(negedge clk);
    check("after_hold_addr", {31'h0, imem_req, imem_addr}, {32'h1, s_pc + 32'd4});

    // redirect while waiting for a slow response
    wait_grant(1'b1);
    drive_point();
    redirect = 1'b1; redirect_pc = 32'h100;
    drive_point();
    redirect = 1'b0;
    @(negedge clk);
    check("wait_redir_valid_n1", {63'h0, instr_valid}, 64'h0);
    @(negedge clk);
    check("wait_redir_drop", {62'h0, imem_req, instr_valid}, 64'h0);
    @(negedge clk);
    check("wait_redir_addr", {31'h0, imem_req, imem_addr}, {32'h1, 32'h100});
    check("wait_redir_valid", {63'h0, instr_valid}, 64'h0);

    // redirect during an ungranted request
    drive_point();
    gnt_mode = 2;
    rv_delay = 0;
    wait_req();
    a_old = imem_addr;
    drive_point();
    redirect = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    check("req_redir_addr_n1", {31'h0, imem_req, imem_addr}, {32'h1, a_old});
    drive_point();
    redirect = 1'b0;
    @(negedge clk);
    check("req_redir_addr_n2", {31'h0, imem_req, imem_addr}, {32'h1, a_old});
    drive_point();
    gnt_mode = 1;
    @(negedge clk);
    check("req_redir_addr_n3", {31'h0, imem_req, imem_addr}, {32'h1, a_old});
    @(negedge clk);
    check("req_redir_wait", {62'h0, imem_req, instr_valid}, 64'h0);
    @(negedge clk);
    check("req_redir_new_addr", {31'h0, imem_req, imem_addr}, {32'h1, 32'h200});

    // PC wrap at the top of the address space
    drive_point();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    drive_point();
    redirect = 1'b0;
    wait_grant_addr(32'hFFFF_FFFC);
    wait_req();
    check("wrap_addr", {32'h0, imem_addr}, 64'h0);

    // asynchronous reset while a response is outstanding
    drive_point();
    rv_delay = 2;
    wait_grant(1'b0);
    drive_point();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rv_delay = -1;
    @(negedge clk);
    check("restart_idle_req", {63'h0, imem_req}, 64'h0);
    @(negedge clk);
    check("restart_addr", {31'h0, imem_req, imem_addr}, {32'h1, RST_PC});

    // random traffic, back-pressure and redirects
    gnt_mode    = 0;
    spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive_point();
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 12'($urandom_range(0, 4095))};
    end
    drive_point();
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    check("random_progress", 64'(n_accept >= 100), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
